// File: rtl/partial_sum_accumulator.sv
// Burst accumulator: NUM_TERMS unsigned 25-bit terms summed into a 44-bit running sum.
// Define ACC_SATURATE_EN to clamp at all-ones after any carry-out instead of wrapping.
module partial_sum_accumulator #(
    parameter int NUM_TERMS = 19,
    localparam int CNT_W = $clog2(NUM_TERMS + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [43:0] init_value,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [43:0] out_sum,
    output logic        out_overflow,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

    state_t           state_q, state_d;
    logic [43:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [44:0]      sum;

    // Single arithmetic path: 44-bit accumulator plus zero-extended term.
    assign sum = {1'b0, acc_q} + {20'd0, in_data};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = init_value;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
`ifdef ACC_SATURATE_EN
                    acc_d = (sum[44] || ovf_q) ? '1 : sum[43:0];
`else
                    acc_d = sum[43:0];
`endif
                    ovf_d = ovf_q | sum[44];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come from registered state only; result is masked outside DONE.
    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == DONE);
    assign out_sum      = (state_q == DONE) ? acc_q : '0;
    assign out_overflow = (state_q == DONE) && ovf_q;
    assign busy         = (state_q != IDLE);

endmodule
